// File: rtl/tqvp_prism_comm_fifo.sv
// Receive-byte FIFO behind the PRISM comm shift register, popped over the peripheral bus.
// Optional non-destructive head read at ADDR_PEEK is enabled by defining COMM_FIFO_PEEK_EN.
module tqvp_prism_comm_fifo #(
  parameter int         DEPTH     = 8,
  parameter logic [5:0] ADDR_DATA = 6'h20,
  parameter logic [5:0] ADDR_STAT = 6'h24,
  parameter logic [5:0] ADDR_PEEK = 6'h2C
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_valid,
  input  logic [7:0]  push_data,
  output logic        fifo_full,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        fifo_irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          ovf, thr_ie, ovf_ie, rd_q, irq_q;
  logic [4:0]    thresh;

  logic       empty, full, rd_data, pop, push_ok, ovf_set;
  logic       stat_wr, flush, ovf_clr, irq_next;
  logic [4:0] count5;
  logic [7:0] head;
  logic       unused_bits;

  assign count5  = 5'(count);
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign rd_data = (data_read_n != 2'b11) && (address == ADDR_DATA);
  // Only the first cycle of a held read pops.
  assign pop     = rd_data && !rd_q && !empty;
  assign push_ok = push_valid && (!full || pop);
  assign ovf_set = push_valid && full && !pop;
  assign stat_wr = (data_write_n == 2'b10) && (address == ADDR_STAT);
  assign flush   = stat_wr && data_in[30];
  assign ovf_clr = stat_wr && data_in[31];
  assign irq_next = (thr_ie && (thresh != 5'd0) && (count5 >= thresh)) || (ovf_ie && ovf);

  assign fifo_full   = full;
  assign fifo_irq    = irq_q;
  assign data_ready  = 1'b1;
  assign unused_bits = ^{data_in[29:26], data_in[23:21], data_in[15:0]};

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      thresh <= '0;
      thr_ie <= 1'b0;
      ovf_ie <= 1'b0;
      rd_q   <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      rd_q  <= rd_data;
      irq_q <= irq_next;
      // A new overflow outranks a same-cycle W1C.
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      if (stat_wr) begin
        thresh <= data_in[20:16];
        thr_ie <= data_in[24];
        ovf_ie <= data_in[25];
      end
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        if (push_ok && !pop)      count <= count + 1'b1;
        else if (!push_ok && pop) count <= count - 1'b1;
      end
    end
  end

  // The byte field is forced to zero while empty so a stale slot never leaks out.
  assign head = empty ? 8'h00 : mem[rd_ptr];

  always_comb begin
    data_out = 32'h0;
    case (address)
      ADDR_DATA: data_out = {23'b0, empty, head};
      ADDR_STAT: begin
        data_out[4:0]   = count5;
        data_out[8]     = empty;
        data_out[9]     = full;
        data_out[10]    = ovf;
        data_out[20:16] = thresh;
        data_out[24]    = thr_ie;
        data_out[25]    = ovf_ie;
      end
`ifdef COMM_FIFO_PEEK_EN
      ADDR_PEEK: data_out = {23'b0, empty, head};
`endif
      default: data_out = 32'h0;
    endcase
  end

endmodule
